// File: rtl/beef_pkg.sv
// Shared opcodes, state encoding and widths for the bracket-matching PC sequencer.
// PC_SEQ_FAULT_EN adds the FAULT state to the state enum.
package beef_pkg;

  localparam int PC_W = 16;

  localparam logic [8:0] OP_OPEN  = 9'h05B;
  localparam logic [8:0] OP_CLOSE = 9'h05D;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_SEARCH_FWD,
    ST_SEARCH_BACK,
    ST_HALT
`ifdef PC_SEQ_FAULT_EN
    ,
    ST_FAULT
`endif
  } pc_seq_state_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch-side bundle between the instruction fetch stage and the PC sequencer.
interface pc_sequencer_if;
  logic [8:0]  inst_at_pc;
  logic        stall;
  logic        jump_fwd;
  logic        jump_back;
  logic        halt_req;
  logic [15:0] pc;
  logic        searching;
  logic        search_dir;
  logic        halted;
  logic        fault;

  modport master (
    output inst_at_pc, stall, jump_fwd, jump_back, halt_req,
    input  pc, searching, search_dir, halted, fault
  );

  modport slave (
    input  inst_at_pc, stall, jump_fwd, jump_back, halt_req,
    output pc, searching, search_dir, halted, fault
  );
endinterface

// File: rtl/pc_sequencer_bracket_depth.sv
// Bracket nesting counter used during a search; saturation/fault decisions live in the caller.
module bracket_depth #(
  parameter int DEPTH_W = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic dec,
  input  logic load1,
  output logic max,
  output logic is_one
);

  logic [DEPTH_W-1:0] r_depth;

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset)      r_depth <= '0;
    else if (load1) r_depth <= DEPTH_W'(1);
    else if (inc)   r_depth <= r_depth + DEPTH_W'(1);
    else if (dec)   r_depth <= r_depth - DEPTH_W'(1);
  end

  assign max    = &r_depth;
  assign is_one = (r_depth == DEPTH_W'(1));

endmodule

// File: rtl/pc_sequencer.sv
// PC sequencer: linear fetch plus bracket-matching forward/backward search.
// Define PC_SEQ_FAULT_EN to trap depth overflow and unmatched searches in a FAULT state.
module pc_sequencer
  import beef_pkg::*;
#(
  parameter int              DEPTH_W  = 8,
  parameter logic [PC_W-1:0] RESET_PC = 16'h0000
) (
  input  logic           clk,
  input  logic           reset,
  pc_sequencer_if.slave  bus
);

  pc_seq_state_t   r_state, w_state_nxt;
  logic [PC_W-1:0] r_pc, w_pc_nxt;
  logic            w_inc, w_dec, w_load1;
  logic            w_depth_max, w_depth_one;

  bracket_depth #(.DEPTH_W(DEPTH_W)) u_depth (
    .clk    (clk),
    .reset  (reset),
    .inc    (w_inc),
    .dec    (w_dec),
    .load1  (w_load1),
    .max    (w_depth_max),
    .is_one (w_depth_one)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_RUN;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  // NOTE: every comb output gets a default first so no path leaves a latch behind.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_inc       = 1'b0;
    w_dec       = 1'b0;
    w_load1     = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (bus.halt_req) begin
          w_state_nxt = ST_HALT;
        end else if (bus.stall) begin
          w_pc_nxt = r_pc;
        end else if (bus.jump_fwd) begin
          w_pc_nxt    = r_pc + PC_W'(1);
          w_load1     = 1'b1;
          w_state_nxt = ST_SEARCH_FWD;
        end else if (bus.jump_back) begin
          w_pc_nxt    = r_pc - PC_W'(1);
          w_load1     = 1'b1;
          w_state_nxt = ST_SEARCH_BACK;
        end else begin
          w_pc_nxt = r_pc + PC_W'(1);
        end
      end
      ST_SEARCH_FWD: begin
        if (bus.inst_at_pc == OP_CLOSE && w_depth_one) begin
          w_pc_nxt    = r_pc + PC_W'(1);
          w_state_nxt = ST_RUN;
`ifdef PC_SEQ_FAULT_EN
        end else if ((bus.inst_at_pc == OP_OPEN && w_depth_max) || r_pc == '1) begin
          w_state_nxt = ST_FAULT;
`endif
        end else begin
          w_pc_nxt = r_pc + PC_W'(1);
          w_inc    = (bus.inst_at_pc == OP_OPEN) && !w_depth_max;
          w_dec    = (bus.inst_at_pc == OP_CLOSE);
        end
      end
      ST_SEARCH_BACK: begin
        // Landing is on the word after the matching opener, not on the opener itself.
        if (bus.inst_at_pc == OP_OPEN && w_depth_one) begin
          w_pc_nxt    = r_pc + PC_W'(1);
          w_state_nxt = ST_RUN;
`ifdef PC_SEQ_FAULT_EN
        end else if ((bus.inst_at_pc == OP_CLOSE && w_depth_max) || r_pc == '0) begin
          w_state_nxt = ST_FAULT;
`endif
        end else begin
          w_pc_nxt = r_pc - PC_W'(1);
          w_inc    = (bus.inst_at_pc == OP_CLOSE) && !w_depth_max;
          w_dec    = (bus.inst_at_pc == OP_OPEN);
        end
      end
      ST_HALT: w_state_nxt = ST_HALT;
`ifdef PC_SEQ_FAULT_EN
      ST_FAULT: w_state_nxt = ST_FAULT;
`endif
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    bus.pc         = r_pc;
    bus.searching  = (r_state == ST_SEARCH_FWD) || (r_state == ST_SEARCH_BACK);
    bus.search_dir = (r_state == ST_SEARCH_BACK);
    bus.halted     = (r_state == ST_HALT);
`ifdef PC_SEQ_FAULT_EN
    bus.fault      = (r_state == ST_FAULT);
`else
    bus.fault      = 1'b0;
`endif
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus random bracket programs
// checked against a scan-ahead reference model.
module tb_pc_sequencer;
  import beef_pkg::*;

  typedef struct {
    logic [15:0] pc;
    logic        srch;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pc_sequencer_if bus();
  pc_sequencer_if bus_hi();

  logic [8:0] rom [65536];
  assign bus.inst_at_pc    = rom[bus.pc];
  assign bus_hi.inst_at_pc = rom[bus_hi.pc];

  pc_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  pc_sequencer #(.RESET_PC(16'hFFF0)) dut_hi (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_hi)
  );

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t plan[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.stall = 1'b0;    bus.jump_fwd = 1'b0;    bus.jump_back = 1'b0;    bus.halt_req = 1'b0;
    bus_hi.stall = 1'b0; bus_hi.jump_fwd = 1'b0; bus_hi.jump_back = 1'b0; bus_hi.halt_req = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic clear_rom();
    for (int a = 0; a < 65536; a++) rom[a] = 9'h000;
  endtask

  // Reference: walk the program text counting nesting to find the partner bracket.
  task automatic plan_fwd(input logic [15:0] p);
    logic [15:0] a;
    int d;
    d = 1;
    a = p;
    for (int g = 0; g < 4000 && d != 0; g++) begin
      a = a + 16'd1;
      plan.push_back('{a, 1'b1});
      if (rom[a] == OP_OPEN) d++;
      else if (rom[a] == OP_CLOSE) d--;
    end
    plan.push_back('{a + 16'd1, 1'b0});
  endtask

  task automatic plan_back(input logic [15:0] p);
    logic [15:0] a;
    int d;
    d = 1;
    a = p;
    for (int g = 0; g < 4000 && d != 0; g++) begin
      a = a - 16'd1;
      plan.push_back('{a, 1'b1});
      if (rom[a] == OP_CLOSE) d++;
      else if (rom[a] == OP_OPEN) d--;
    end
    plan.push_back('{a + 16'd1, 1'b0});
  endtask

  task automatic build_random_program();
    int d;
    int r;
    int a;
    logic [8:0] v;
    d = 0;
    for (a = 20; a < 100; a++) begin
      r = $urandom_range(0, 3);
      if (r == 0 && d < 6) begin
        rom[a] = OP_OPEN;
        d++;
      end else if (r == 1 && d > 0) begin
        rom[a] = OP_CLOSE;
        d--;
      end else begin
        v = 9'($urandom_range(0, 511));
        if (v == OP_OPEN || v == OP_CLOSE) v = 9'h02B;
        rom[a] = v;
      end
    end
    for (; d > 0; a++) begin
      rom[a] = OP_CLOSE;
      d--;
    end
  endtask

  task automatic run_random(input int budget);
    logic [15:0] exp_pc;
    exp_t e;
    int r;
    plan.delete();
    do_reset();
    exp_pc = 16'd0;
    check("rnd_reset_pc", bus.pc, 16'd0);
    for (int it = 0; it < budget && exp_pc < 16'd120; it++) begin
      if (plan.size() != 0) begin
        // Inputs during a search must be ignored.
        bus.stall     = 1'($urandom_range(0, 1));
        bus.jump_fwd  = 1'($urandom_range(0, 1));
        bus.jump_back = 1'($urandom_range(0, 1));
        bus.halt_req  = 1'($urandom_range(0, 1));
      end else begin
        r = $urandom_range(0, 9);
        if (rom[exp_pc] == OP_OPEN && r < 6) begin
          bus.jump_fwd = 1'b1;
          plan_fwd(exp_pc);
        end else if (rom[exp_pc] == OP_CLOSE && r < 4) begin
          bus.jump_back = 1'b1;
          plan_back(exp_pc);
        end else if (r >= 8) begin
          bus.stall = 1'b1;
          plan.push_back('{exp_pc, 1'b0});
        end else begin
          plan.push_back('{exp_pc + 16'd1, 1'b0});
        end
      end
      tick();
      clear_inputs();
      e = plan.pop_front();
      check("rnd_pc", bus.pc, e.pc);
      check("rnd_srch", bus.searching, e.srch);
      check("rnd_halt", bus.halted, 1'b0);
      exp_pc = e.pc;
    end
    check("rnd_reached_end", exp_pc >= 16'd120, 1'b1);
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    clear_rom();

    // Reset state and free-running fetch.
    do_reset();
    check("rst_pc", bus.pc, 16'd0);
    check("rst_srch", bus.searching, 1'b0);
    check("rst_dir", bus.search_dir, 1'b0);
    check("rst_halt", bus.halted, 1'b0);
    check("rst_fault", bus.fault, 1'b0);
    check("rst_depth", dut.u_depth.r_depth, 8'd0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("free_pc", bus.pc, 16'(i));
      check("free_srch", bus.searching, 1'b0);
    end

    // Simple forward skip.
    rom[3] = OP_OPEN; rom[4] = 9'h02B; rom[5] = OP_CLOSE; rom[6] = 9'h03E;
    do_reset();
    repeat (3) tick();
    check("fwd_start_pc", bus.pc, 16'd3);
    bus.jump_fwd = 1'b1;
    tick();
    clear_inputs();
    check("fwd_pc4", bus.pc, 16'd4);   check("fwd_srch4", bus.searching, 1'b1);
    check("fwd_dir", bus.search_dir, 1'b0);
    tick();
    check("fwd_pc5", bus.pc, 16'd5);   check("fwd_srch5", bus.searching, 1'b1);
    tick();
    check("fwd_pc6", bus.pc, 16'd6);   check("fwd_srch6", bus.searching, 1'b0);

    // Nested backward search over '[[]]'.
    rom[10] = OP_OPEN; rom[11] = OP_OPEN; rom[12] = OP_CLOSE; rom[13] = OP_CLOSE;
    do_reset();
    repeat (13) tick();
    check("back_start_pc", bus.pc, 16'd13);
    bus.jump_back = 1'b1;
    tick();
    clear_inputs();
    check("back_pc12", bus.pc, 16'd12);  check("back_dep1", dut.u_depth.r_depth, 8'd1);
    check("back_dir", bus.search_dir, 1'b1);
    tick();
    check("back_pc11", bus.pc, 16'd11);  check("back_dep2", dut.u_depth.r_depth, 8'd2);
    tick();
    check("back_pc10", bus.pc, 16'd10);  check("back_dep1b", dut.u_depth.r_depth, 8'd1);
    check("back_srch10", bus.searching, 1'b1);
    tick();
    check("back_land_pc", bus.pc, 16'd11); check("back_land_srch", bus.searching, 1'b0);

    // Stall then halt with simultaneous jump.
    do_reset();
    repeat (7) tick();
    bus.stall = 1'b1;
    tick(); check("stall_pc_a", bus.pc, 16'd7);
    tick(); check("stall_pc_b", bus.pc, 16'd7);
    bus.stall = 1'b0;
    tick(); check("stall_rel_pc", bus.pc, 16'd8);
    bus.jump_fwd = 1'b1;
    bus.halt_req = 1'b1;
    tick();
    clear_inputs();
    check("halt_flag", bus.halted, 1'b1);
    check("halt_pc", bus.pc, 16'd8);
    check("halt_srch", bus.searching, 1'b0);
    bus.jump_back = 1'b1;
    repeat (3) tick();
    clear_inputs();
    check("halt_hold_flag", bus.halted, 1'b1);
    check("halt_hold_pc", bus.pc, 16'd8);
    do_reset();
    check("halt_cleared", bus.halted, 1'b0);

    // Reset in the middle of a backward search.
    do_reset();
    repeat (13) tick();
    bus.jump_back = 1'b1;
    tick();
    clear_inputs();
    check("midrst_srch_pre", bus.searching, 1'b1);
    reset = 1'b1;
    bus.jump_fwd = 1'b1;
    tick();
    reset = 1'b0;
    clear_inputs();
    check("midrst_pc", bus.pc, 16'd0);
    check("midrst_srch", bus.searching, 1'b0);
    check("midrst_depth", dut.u_depth.r_depth, 8'd0);

    // Forward search off the top of the address space.
    for (int a = 16'hFFF0; a <= 16'hFFFF; a++) rom[a] = 9'h02B;
    rom[0] = 9'h000; rom[1] = 9'h000; rom[2] = 9'h000;
    do_reset();
    check("hi_rst_pc", bus_hi.pc, 16'hFFF0);
    bus_hi.jump_fwd = 1'b1;
    tick();
    clear_inputs();
    for (int k = 1; k <= 15; k++) begin
      check("hi_scan_pc", bus_hi.pc, 16'hFFF0 + 16'(k));
      check("hi_scan_srch", bus_hi.searching, 1'b1);
      if (k < 15) tick();
    end
    tick();
`ifdef PC_SEQ_FAULT_EN
    check("hi_fault", bus_hi.fault, 1'b1);
    check("hi_fault_pc", bus_hi.pc, 16'hFFFF);
    check("hi_fault_srch", bus_hi.searching, 1'b0);
    tick();
    check("hi_fault_hold", bus_hi.pc, 16'hFFFF);
`else
    check("hi_wrap_pc", bus_hi.pc, 16'h0000);
    check("hi_wrap_srch", bus_hi.searching, 1'b1);
    check("hi_wrap_fault", bus_hi.fault, 1'b0);
    tick();
    check("hi_wrap_pc1", bus_hi.pc, 16'h0001);
`endif

    // Backward search off the bottom of the address space.
    do_reset();
    repeat (2) tick();
    bus.jump_back = 1'b1;
    tick();
    clear_inputs();
    check("lo_pc1", bus.pc, 16'd1);
    tick();
    check("lo_pc0", bus.pc, 16'd0);
    check("lo_srch0", bus.searching, 1'b1);
    tick();
`ifdef PC_SEQ_FAULT_EN
    check("lo_fault", bus.fault, 1'b1);
    check("lo_fault_pc", bus.pc, 16'd0);
`else
    check("lo_wrap_pc", bus.pc, 16'hFFFF);
    check("lo_wrap_srch", bus.searching, 1'b1);
    check("lo_wrap_dir", bus.search_dir, 1'b1);
`endif

    // Random bracket programs against the scan-ahead model.
    for (int n = 0; n < 4; n++) begin
      clear_rom();
      build_random_program();
      run_random(3000);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have parameter DEPTH_W, default 8: width of the bracket nesting counter.
REQ-002 The block SHALL have parameter RESET_PC, default 16'h0000: the PC value loaded on reset.
REQ-003 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port inst_at_pc, input, 9: raw instruction-ROM word at the current pc, before nop masking.
REQ-006 Port stall, input, 1: fetch is inserting a delay slot; hold pc.
REQ-007 Port jump_fwd, input, 1: '[' is executing with a zero cell; skip to the matching ']'.
REQ-008 Port jump_back, input, 1: ']' is executing with a nonzero cell; return to the matching '['.
REQ-009 Port halt_req, input, 1: the program has ended.
REQ-010 Port pc, output, 16: fetch address.
REQ-011 Port searching, output, 1: high in either search state; drives the fetch nop select.
REQ-012 Port search_dir, output, 1: 1 = backward search; valid only while searching.
REQ-013 Port halted, output, 1: high in the HALT state.
REQ-014 Port fault, output, 1: high in the FAULT state; present only with PC_SEQ_FAULT_EN, else tied 0.

Function
REQ-015 The FSM SHALL have the states RUN, SEARCH_FWD, SEARCH_BACK, HALT and FAULT; searching = (state is SEARCH_FWD or SEARCH_BACK).
REQ-016 In RUN, inputs SHALL be handled in this priority order:
- halt_req: go to HALT, hold pc.
- stall: hold pc.
- jump_fwd: pc<=pc+1, depth<=1, go to SEARCH_FWD.
- jump_back: pc<=pc-1, depth<=1, go to SEARCH_BACK.
- otherwise: pc<=pc+1.
REQ-017 In SEARCH_FWD, the block SHALL act on inst_at_pc each cycle:
- OP_OPEN: depth+1, pc+1.
- OP_CLOSE with depth==1: pc<=pc+1, go to RUN.
- OP_CLOSE otherwise: depth-1, pc+1.
- any other opcode: pc+1.
REQ-018 In SEARCH_BACK, the block SHALL act on inst_at_pc each cycle:
- OP_CLOSE: depth+1, pc-1.
- OP_OPEN with depth==1: pc<=pc+1 (the instruction after '['), go to RUN.
- OP_OPEN otherwise: depth-1, pc-1.
- any other opcode: pc-1.
REQ-019 While searching, the block SHALL ignore stall, jump_fwd, jump_back and halt_req.
REQ-020 Search latency SHALL be one cycle per scanned word; the match cycle itself counts as one cycle.
REQ-021 HALT SHALL be absorbing until reset; pc holds.
REQ-022 PC arithmetic SHALL be 16-bit modulo; depth arithmetic SHALL be DEPTH_W-bit unsigned.

Reset
REQ-023 While reset is high, the block SHALL drive pc=RESET_PC, state=RUN, depth=0, searching=0, search_dir=0, halted=0, fault=0 on the next edge.
REQ-024 Reset SHALL take precedence over every other input, including reset asserted mid-search.

Configuration
REQ-025 With macro PC_SEQ_FAULT_EN defined, the block SHALL enter FAULT (pc holds, absorbing until reset) on any of:
- an opener seen while depth is at its maximum;
- SEARCH_FWD at pc=16'hFFFF with no match;
- SEARCH_BACK at pc=0 with no match.
REQ-026 Without PC_SEQ_FAULT_EN, depth SHALL saturate at its maximum, pc SHALL wrap modulo 2^16, the FAULT state SHALL be absent, and fault SHALL be constant 0.

Structure
REQ-027 Shared package beef_pkg SHALL hold:
- the 9-bit constants OP_OPEN and OP_CLOSE;
- the pc_seq_state_t enum;
- the constant PC_W=16.
REQ-028 Sub-module bracket_depth SHALL implement the depth counter, with inc, dec, load1, max and is_one ports.

Verification
REQ-029 Reset then 4 free cycles -> pc 0,1,2,3,4; searching=0.
REQ-030 Words 3:'[', 4:'+', 5:']', 6:'>'; jump_fwd at pc=3 -> pc 4,5 with searching=1, then pc=6 with searching=0 after 3 cycles.
REQ-031 Nested case '[[]]' at 10..13; jump_back at pc=13 -> depth 1,2,1 observed, then pc=11 in RUN.
REQ-032 stall for 2 cycles at pc=7 -> pc stays 7 for 2 cycles, then 8; jump_fwd asserted together with halt_req -> HALT.
REQ-033 With PC_SEQ_FAULT_EN: jump_fwd at pc=16'hFFF0 with no ']' -> fault=1 at 16'hFFFF. Without the macro: pc wraps to 0 and searching stays 1.
REQ-034 reset asserted during SEARCH_BACK -> next cycle pc=RESET_PC, searching=0, depth=0.
